// File: rtl/efuse_access_arbiter.sv
// Arbitrates the single efuse_controller command port between the autoload requester (r0)
// and the I2C requester (r1), with a grant-to-done watchdog. Define EFUSE_ARB_RR_EN for round-robin.
module efuse_access_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 4096,
  parameter int unsigned DW          = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          r0_req,
  input  logic          r0_wr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_done,
  output logic          r0_err,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_req,
  input  logic          r1_wr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_done,
  output logic          r1_err,
  output logic [DW-1:0] r1_rdata,
  output logic          write,
  output logic          read,
  input  logic          ack,
  output logic [DW-1:0] data_write,
  input  logic [DW-1:0] data_read,
  input  logic          wr_done,
  input  logic          rd_done,
  output logic          busy,
  output logic [1:0]    grant
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StComplete} state_e;

  localparam logic [11:0] TimeoutLast = 12'(TIMEOUT_CYC - 1);

  state_e        state_q;
  logic [11:0]   cnt_q;
  logic          op_wr_q;
  logic [1:0]    grant_q;
  logic          write_q, read_q, busy_q;
  logic          r0_done_q, r0_err_q, r1_done_q, r1_err_q;
  logic [DW-1:0] r0_rdata_q, r1_rdata_q, data_write_q;

  logic pick0, pick1, sel_wr, done_match, timeout, fin_ok, fin_err;

`ifdef EFUSE_ARB_RR_EN
  logic last_q;
  // On a tie, the requester that did not own the port last time wins.
  assign pick1 = r1_req && (!r0_req || !last_q);
`else
  assign pick1 = r1_req && !r0_req;
`endif
  assign pick0  = r0_req && !pick1;
  assign sel_wr = pick1 ? r1_wr : r0_wr;

  assign done_match = op_wr_q ? wr_done : rd_done;
  assign timeout    = (cnt_q == TimeoutLast);
  // Ack and done together in ISSUE is taken as a complete handshake.
  assign fin_ok  = ((state_q == StIssue && ack) || state_q == StWait) && done_match;
  assign fin_err = (state_q == StIssue || state_q == StWait) && timeout && !fin_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      op_wr_q      <= 1'b0;
      grant_q      <= 2'b00;
      write_q      <= 1'b0;
      read_q       <= 1'b0;
      busy_q       <= 1'b0;
      r0_done_q    <= 1'b0;
      r0_err_q     <= 1'b0;
      r1_done_q    <= 1'b0;
      r1_err_q     <= 1'b0;
      r0_rdata_q   <= '0;
      r1_rdata_q   <= '0;
      data_write_q <= '0;
`ifdef EFUSE_ARB_RR_EN
      last_q       <= 1'b0;
`endif
    end else begin
      r0_done_q <= 1'b0;
      r0_err_q  <= 1'b0;
      r1_done_q <= 1'b0;
      r1_err_q  <= 1'b0;
      if (fin_ok || fin_err) begin
        write_q   <= 1'b0;
        read_q    <= 1'b0;
        r0_done_q <= grant_q[0];
        r1_done_q <= grant_q[1];
        r0_err_q  <= grant_q[0] && fin_err;
        r1_err_q  <= grant_q[1] && fin_err;
        if (fin_ok && !op_wr_q) begin
          if (grant_q[0]) r0_rdata_q <= data_read;
          else            r1_rdata_q <= data_read;
        end
        state_q <= StComplete;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (pick0 || pick1) begin
              grant_q      <= pick1 ? 2'b10 : 2'b01;
              op_wr_q      <= sel_wr;
              data_write_q <= sel_wr ? (pick1 ? r1_wdata : r0_wdata) : '0;
              write_q      <= sel_wr;
              read_q       <= !sel_wr;
              busy_q       <= 1'b1;
              cnt_q        <= '0;
              state_q      <= StIssue;
            end
          end
          StIssue: begin
            cnt_q <= cnt_q + 12'd1;
            if (ack) begin
              write_q <= 1'b0;
              read_q  <= 1'b0;
              state_q <= StWait;
            end
          end
          StWait: begin
            cnt_q <= cnt_q + 12'd1;
          end
          StComplete: begin
            grant_q      <= 2'b00;
            busy_q       <= 1'b0;
            data_write_q <= '0;
`ifdef EFUSE_ARB_RR_EN
            last_q       <= grant_q[1];
`endif
            state_q      <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign r0_done    = r0_done_q;
  assign r0_err     = r0_err_q;
  assign r0_rdata   = r0_rdata_q;
  assign r1_done    = r1_done_q;
  assign r1_err     = r1_err_q;
  assign r1_rdata   = r1_rdata_q;
  assign write      = write_q;
  assign read       = read_q;
  assign data_write = data_write_q;
  assign busy       = busy_q;
  assign grant      = grant_q;

endmodule

// File: tb/tb_efuse_access_arbiter.sv
// Directed bench for efuse_access_arbiter with a short watchdog (TIMEOUT_CYC = 16).
module tb_efuse_access_arbiter;

  logic        clk, rst_n;
  logic        r0_req, r0_wr, r0_done, r0_err;
  logic [31:0] r0_wdata, r0_rdata;
  logic        r1_req, r1_wr, r1_done, r1_err;
  logic [31:0] r1_wdata, r1_rdata;
  logic        write, read, ack, wr_done, rd_done, busy;
  logic [31:0] data_write, data_read;
  logic [1:0]  grant;

  int passes = 0;
  int total  = 0;
  bit rr;
  logic [1:0] g1, g2;

  efuse_access_arbiter #(.TIMEOUT_CYC(16), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req(r0_req), .r0_wr(r0_wr), .r0_wdata(r0_wdata),
    .r0_done(r0_done), .r0_err(r0_err), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_wr(r1_wr), .r1_wdata(r1_wdata),
    .r1_done(r1_done), .r1_err(r1_err), .r1_rdata(r1_rdata),
    .write(write), .read(read), .ack(ack),
    .data_write(data_write), .data_read(data_read),
    .wr_done(wr_done), .rd_done(rd_done), .busy(busy), .grant(grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
`ifdef EFUSE_ARB_RR_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    rst_n = 1'b0;
    {r0_req, r0_wr, r1_req, r1_wr, ack, wr_done, rd_done} = '0;
    r0_wdata = '0; r1_wdata = '0; data_read = '0;
    step(2);
    check("rst_busy", busy, 0);
    check("rst_grant", grant, 0);
    check("rst_wr_rd", {write, read}, 0);
    check("rst_done", {r0_done, r1_done, r0_err, r1_err}, 0);
    check("rst_rdata0", r0_rdata, 0);
    check("rst_dw", data_write, 0);
    rst_n = 1'b1;
    step(1);

    // r0 read, ack after two cycles of read
    r0_req = 1'b1; r0_wr = 1'b0;
    step(1);
    check("t1_read_c1", read, 1);
    check("t1_grant", grant, 2'b01);
    check("t1_busy", busy, 1);
    step(1);
    check("t1_read_c2", read, 1);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    check("t1_read_drop", read, 0);
    step(4);
    rd_done = 1'b1; data_read = 32'hA5A5_0F0F;
    step(1);
    rd_done = 1'b0; data_read = '0; r0_req = 1'b0;
    check("t1_done", r0_done, 1);
    check("t1_err", r0_err, 0);
    check("t1_rdata0", r0_rdata, 32'hA5A5_0F0F);
    check("t1_rdata1", r1_rdata, 0);
    step(1);
    check("t1_done_pulse", r0_done, 0);
    check("t1_idle", {busy, grant}, 0);

    // r1 program with a spurious rd_done while waiting
    r1_req = 1'b1; r1_wr = 1'b1; r1_wdata = 32'h0000_00C3;
    step(1);
    check("t2_write", write, 1);
    check("t2_grant", grant, 2'b10);
    check("t2_dw_issue", data_write, 32'h0000_00C3);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    check("t2_write_drop", write, 0);
    rd_done = 1'b1;
    step(1);
    rd_done = 1'b0;
    check("t2_spurious", {busy, r1_done}, 2'b10);
    check("t2_dw_wait", data_write, 32'h0000_00C3);
    wr_done = 1'b1;
    step(1);
    wr_done = 1'b0; r1_req = 1'b0;
    check("t2_done", {r1_done, r1_err}, 2'b10);
    check("t2_rdata1", r1_rdata, 0);
    step(1);
    check("t2_idle", {busy, r1_done}, 0);

    // r0 read with no ack: watchdog abort after 16 ISSUE cycles
    r0_req = 1'b1; r0_wr = 1'b0;
    step(1);
    check("t4_read_c1", read, 1);
    step(15);
    check("t4_read_c16", {read, busy, r0_done}, 3'b110);
    step(1);
    r0_req = 1'b0;
    check("t4_read_drop", read, 0);
    check("t4_done_err", {r0_done, r0_err}, 2'b11);
    check("t4_rdata0", r0_rdata, 32'hA5A5_0F0F);
    step(1);
    check("t4_idle", {busy, r0_done, r0_err}, 0);

    // Simultaneous reads; second one uses ack+rd_done together
    g1 = rr ? 2'b10 : 2'b01;
    g2 = ~g1;
    r0_req = 1'b1; r1_req = 1'b1; r0_wr = 1'b0; r1_wr = 1'b0;
    step(1);
    check("t3_grant1", grant, g1);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    rd_done = 1'b1; data_read = 32'h1111_1111;
    step(1);
    rd_done = 1'b0;
    if (g1[0]) r0_req = 1'b0; else r1_req = 1'b0;
    check("t3_done1", {r1_done, r0_done}, g1);
    check("t3_rdata1", g1[0] ? r0_rdata : r1_rdata, 32'h1111_1111);
    step(1);
    check("t3_gap", {busy, grant}, 0);
    step(1);
    check("t3_grant2", grant, g2);
    ack = 1'b1; rd_done = 1'b1; data_read = 32'h2222_2222;
    step(1);
    ack = 1'b0; rd_done = 1'b0; r0_req = 1'b0; r1_req = 1'b0;
    check("t6_direct_done", {r1_done, r0_done}, g2);
    check("t6_read", read, 0);
    check("t6_rdata2", g2[0] ? r0_rdata : r1_rdata, 32'h2222_2222);
    check("t6_rdata_other", g1[0] ? r0_rdata : r1_rdata, 32'h1111_1111);
    step(1);
    check("t6_single_pulse", {busy, r1_done, r0_done}, 0);

    // Async reset during WAIT_DONE of an r1 program, r0 pending
    r1_req = 1'b1; r1_wr = 1'b1; r1_wdata = 32'h0000_005A;
    step(1);
    ack = 1'b1;
    step(1);
    ack = 1'b0; r0_req = 1'b1; r0_wr = 1'b0;
    check("t5_wait_busy", {busy, grant}, 3'b110);
    #2 rst_n = 1'b0; r1_req = 1'b0;
    #1;
    check("t5_async", {write, read, grant, busy}, 0);
    check("t5_no_done", r1_done, 0);
    rst_n = 1'b1;
    step(1);
    check("t5_regrant", {grant, read}, 3'b011);
    check("t5_no_done2", r1_done, 0);
    ack = 1'b1;
    step(1);
    ack = 1'b0; rd_done = 1'b1; data_read = 32'h0BAD_CAFE;
    step(1);
    rd_done = 1'b0; r0_req = 1'b0;
    check("t5_done", {r0_done, r0_err}, 2'b10);
    check("t5_rdata0", r0_rdata, 32'h0BAD_CAFE);
    step(1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
